// File: rtl/hssl_apb_pkg.sv
// Shared types and constants for the hssl_reg_bank APB initiator: FSM states,
// the timeout read-data pattern and register-bank address field layout.
package hssl_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] HSSL_APB_DEAD_BEEF = 32'hdead_beef;

  // Register-bank sections, found at address bits [8:6].
  localparam logic [2:0] HREGS = 3'd0;
  localparam logic [2:0] KREGS = 3'd1;
  localparam logic [2:0] MREGS = 3'd2;
  localparam logic [2:0] RREGS = 3'd3;
  localparam logic [2:0] CREGS = 3'd4;
  localparam logic [2:0] AREGS = 3'd5;
  localparam logic [2:0] SREGS = 3'd6;

  localparam int unsigned SECT_LSB  = 6;
  localparam int unsigned SECT_BITS = 3;
  localparam int unsigned REG_LSB   = 2;
  localparam int unsigned REG_BITS  = 4;

  // Byte offset of a register inside the bank, for initiators and benches.
  function automatic logic [8:0] hssl_reg_offset(input logic [2:0] section,
                                                 input logic [3:0] regnum);
    hssl_reg_offset = {section, regnum, 2'b00};
  endfunction

endpackage

// File: rtl/hssl_apb_master.sv
// Single-outstanding APB3 initiator for the hssl_reg_bank configuration port.
// Optional ACCESS-phase timeout is enabled by defining HSSL_APB_TIMEOUT_EN.
module hssl_apb_master
  import hssl_apb_pkg::*;
#(
  parameter int ADDR_BITS      = 40,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic                 cmd_write_in,
  input  logic [ADDR_BITS-1:0] cmd_addr_in,
  input  logic [DATA_BITS-1:0] cmd_wdata_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic                 rsp_write_out,
  output logic [DATA_BITS-1:0] rsp_rdata_out,
  output logic                 rsp_err_out,
  output logic                 apb_psel_out,
  output logic                 apb_penable_out,
  output logic                 apb_pwrite_out,
  output logic [ADDR_BITS-1:0] apb_paddr_out,
  output logic [DATA_BITS-1:0] apb_pwdata_out,
  input  logic [DATA_BITS-1:0] apb_prdata_in,
  input  logic                 apb_pready_in,
  input  logic                 apb_pslverr_in
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("hssl_apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  apb_state_e state_r;

`ifdef HSSL_APB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_r;
`endif

  assign cmd_ready_out = (state_r == IDLE);

  // Transaction sequencer; the APB pins double as the command holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_pwrite_out  <= 1'b0;
      apb_paddr_out   <= '0;
      apb_pwdata_out  <= '0;
      rsp_valid_out   <= 1'b0;
      rsp_write_out   <= 1'b0;
      rsp_rdata_out   <= '0;
      rsp_err_out     <= 1'b0;
`ifdef HSSL_APB_TIMEOUT_EN
      wait_cnt_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid_in) begin
            state_r        <= SETUP;
            apb_psel_out   <= 1'b1;
            apb_pwrite_out <= cmd_write_in;
            apb_paddr_out  <= {cmd_addr_in[ADDR_BITS-1:2], 2'b00};
            apb_pwdata_out <= cmd_wdata_in;
          end
        end
        SETUP: begin
          state_r         <= ACCESS;
          apb_penable_out <= 1'b1;
`ifdef HSSL_APB_TIMEOUT_EN
          wait_cnt_r      <= 8'd0;
`endif
        end
        ACCESS: begin
          if (apb_pready_in) begin
            state_r         <= RESP;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_valid_out   <= 1'b1;
            rsp_write_out   <= apb_pwrite_out;
            rsp_rdata_out   <= apb_pwrite_out ? '0 : apb_prdata_in;
            rsp_err_out     <= apb_pslverr_in;
`ifdef HSSL_APB_TIMEOUT_EN
          end else if (wait_cnt_r == WAIT_LAST) begin
            // Slave never answered: abandon the transfer and report it.
            state_r         <= RESP;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_valid_out   <= 1'b1;
            rsp_write_out   <= apb_pwrite_out;
            rsp_rdata_out   <= DATA_BITS'(HSSL_APB_DEAD_BEEF);
            rsp_err_out     <= 1'b1;
          end else begin
            wait_cnt_r      <= wait_cnt_r + 8'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready_in) begin
            state_r       <= IDLE;
            rsp_valid_out <= 1'b0;
          end
        end
        default: begin
          state_r         <= IDLE;
          apb_psel_out    <= 1'b0;
          apb_penable_out <= 1'b0;
          rsp_valid_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hssl_apb_master.sv
// Bench for hssl_apb_master: transaction-level reference model checked every
// cycle, plus directed cycle-exact expectations; honours HSSL_APB_TIMEOUT_EN.
module tb_hssl_apb_master;

  localparam int AW = 40;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef HSSL_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b1, pslverr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  hssl_apb_master #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_write_in(cmd_write),
    .cmd_addr_in(cmd_addr), .cmd_wdata_in(cmd_wdata),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_write_out(rsp_write),
    .rsp_rdata_out(rsp_rdata), .rsp_err_out(rsp_err),
    .apb_psel_out(psel), .apb_penable_out(penable), .apb_pwrite_out(pwrite),
    .apb_paddr_out(paddr), .apb_pwdata_out(pwdata), .apb_prdata_in(prdata),
    .apb_pready_in(pready), .apb_pslverr_in(pslverr)
  );

  always #5 clk = ~clk;

  // Reference model: what the bus and response channel must show, by APB phase.
  bit          m_ready = 1'b1, m_psel = 1'b0, m_pen = 1'b0, m_pwrite = 1'b0;
  bit [AW-1:0] m_paddr = '0;
  bit [DW-1:0] m_pwdata = '0, m_rdata = '0;
  bit          m_rvalid = 1'b0, m_rwrite = 1'b0, m_rerr = 1'b0;
  int          m_waits = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b1; m_psel = 1'b0; m_pen = 1'b0; m_pwrite = 1'b0;
      m_paddr = '0; m_pwdata = '0; m_rvalid = 1'b0; m_rwrite = 1'b0;
      m_rdata = '0; m_rerr = 1'b0;
    end else if (m_ready) begin
      if (cmd_valid) begin
        m_ready  = 1'b0;
        m_psel   = 1'b1;
        m_pwrite = cmd_write;
        m_paddr  = {cmd_addr[AW-1:2], 2'b00};
        m_pwdata = cmd_wdata;
      end
    end else if (m_psel && !m_pen) begin
      m_pen   = 1'b1;
      m_waits = 0;
    end else if (m_pen) begin
      if (pready) begin
        m_psel = 1'b0; m_pen = 1'b0; m_rvalid = 1'b1; m_rwrite = m_pwrite;
        m_rdata = m_pwrite ? '0 : prdata;
        m_rerr  = pslverr;
      end else begin
        m_waits++;
        if (TO_EN && m_waits == TO) begin
          m_psel = 1'b0; m_pen = 1'b0; m_rvalid = 1'b1; m_rwrite = m_pwrite;
          m_rdata = 32'hdead_beef;
          m_rerr  = 1'b1;
        end
      end
    end else if (m_rvalid && rsp_ready) begin
      m_rvalid = 1'b0;
      m_ready  = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
      chk("psel", 64'(psel), 64'(m_psel));
      chk("penable", 64'(penable), 64'(m_pen));
      chk("pwrite", 64'(pwrite), 64'(m_pwrite));
      chk("paddr", 64'(paddr), 64'(m_paddr));
      chk("pwdata", 64'(pwdata), 64'(m_pwdata));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rvalid));
      if (m_rvalid) begin
        chk("rsp_write", 64'(rsp_write), 64'(m_rwrite));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(m_rerr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    cmd_valid = 1'b0; pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: model never returned to idle within 40 cycles");
    end
  endtask

  // Presents one command, leaves the bench in cycle 1 (SETUP).
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reset_mid();
    reset = 1'b1;
    tick();
    chk("rst_mid_psel", 64'(psel), 64'd0);
    chk("rst_mid_penable", 64'(penable), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_psel", 64'(psel), 64'd0);
    chk("reset_paddr", 64'(paddr), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Write, zero wait states.
    wait_idle();
    issue(1'b1, 40'h104, 32'h1234_5678);
    chk("wr_c1_psel", 64'(psel), 64'd1);
    chk("wr_c1_penable", 64'(penable), 64'd0);
    chk("wr_c1_paddr", 64'(paddr), 64'h104);
    chk("wr_c1_pwdata", 64'(pwdata), 64'h1234_5678);
    chk("wr_c1_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("wr_c2_psel", 64'(psel), 64'd1);
    chk("wr_c2_penable", 64'(penable), 64'd1);
    tick();
    chk("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_c3_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_c3_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("wr_c3_rsp_write", 64'(rsp_write), 64'd1);
    chk("wr_c3_psel", 64'(psel), 64'd0);
    tick();
    chk("wr_c4_cmd_ready", 64'(cmd_ready), 64'd1);

    // Read with three wait states.
    wait_idle();
    issue(1'b0, 40'h084, 32'h0);
    pready = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        pready = 1'b1;
        prdata = 32'hcafe_f00d;
      end
      chk("rd_access_penable", 64'(penable), 64'd1);
      chk("rd_access_paddr", 64'(paddr), 64'h084);
      chk("rd_access_pwrite", 64'(pwrite), 64'd0);
      chk("rd_access_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    tick();
    chk("rd_c6_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_c6_rsp_rdata", 64'(rsp_rdata), 64'hcafe_f00d);

    // Slave error and address alignment.
    wait_idle();
    prdata = 32'h5a5a_0003;
    pslverr = 1'b1;
    issue(1'b0, 40'h003, 32'h0);
    chk("err_paddr_aligned", 64'(paddr), 64'h000);
    tick();
    tick();
    chk("err_rsp_err", 64'(rsp_err), 64'd1);
    chk("err_rsp_rdata", 64'(rsp_rdata), 64'h5a5a_0003);
    pslverr = 1'b0;

    // Response backpressure with a second command pending.
    wait_idle();
    rsp_ready = 1'b0;
    cmd_write = 1'b1; cmd_addr = 40'h1c8; cmd_wdata = 32'h1111_2222; cmd_valid = 1'b1;
    tick();
    cmd_write = 1'b0; cmd_addr = 40'h148; cmd_wdata = 32'h3333_4444;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("bp_c8_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("bp_c9_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("bp_c9_psel", 64'(psel), 64'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_c10_psel", 64'(psel), 64'd1);
    chk("bp_c10_penable", 64'(penable), 64'd0);
    chk("bp_c10_paddr", 64'(paddr), 64'h148);

    // Stuck slave: timeout when enabled, indefinite wait otherwise.
    wait_idle();
    pready = 1'b0;
    issue(1'b1, 40'h2c0, 32'h0bad_0bad);
`ifdef HSSL_APB_TIMEOUT_EN
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("to_access_penable", 64'(penable), 64'd1);
    end
    tick();
    chk("to_psel", 64'(psel), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'hdead_beef);
    wait_idle();
    pready = 1'b0;
    issue(1'b0, 40'h010, 32'h0);
    tick();
    tick();
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("stall_psel", 64'(psel), 64'd1);
    chk("stall_penable", 64'(penable), 64'd1);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd0);
`endif
    reset_mid();

    // Randomized traffic against the model.
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 0);
      cmd_write = ($urandom_range(0, 1) == 0);
      cmd_addr  = AW'({$urandom(), $urandom()});
      cmd_wdata = $urandom();
      rsp_ready = ($urandom_range(0, 2) != 0);
      pready    = ($urandom_range(0, 3) != 0);
      pslverr   = ($urandom_range(0, 3) == 0);
      prdata    = $urandom();
      tick();
    end
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hssl_apb_master.md
# hssl_apb_master

APB initiator that turns single register-access commands into APB3 transactions on the `hssl_reg_bank` configuration port. It sits between the configuration/command path and the register bank's APB slave interface. It serialises one access at a time, waits out slave wait states (`pready` low), and returns read data and error status on a valid/ready response channel.

## Interface

**Parameters**
- `ADDR_BITS`, default 40: APB address width.
- `DATA_BITS`, default 32: APB data width.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS-phase length. Only used with `HSSL_APB_TIMEOUT_EN`. Range 1..255.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock.
- `reset` in 1: synchronous reset, active high.
- `cmd_valid_in` in 1: command valid.
- `cmd_ready_out` out 1: command accepted when valid && ready.
- `cmd_write_in` in 1: 1 = write, 0 = read.
- `cmd_addr_in` in ADDR_BITS: byte address.
- `cmd_wdata_in` in DATA_BITS: write data.
- `rsp_valid_out` out 1: response valid.
- `rsp_ready_in` in 1: response consumed when valid && ready.
- `rsp_write_out` out 1: response belongs to a write.
- `rsp_rdata_out` out DATA_BITS: read data. Always 0 for writes.
- `rsp_err_out` out 1: slave error or timeout.
- `apb_psel_out` out 1: APB select.
- `apb_penable_out` out 1: APB enable.
- `apb_pwrite_out` out 1: APB direction.
- `apb_paddr_out` out ADDR_BITS: APB address.
- `apb_pwdata_out` out DATA_BITS: APB write data.
- `apb_prdata_in` in DATA_BITS: APB read data.
- `apb_pready_in` in 1: slave ready.
- `apb_pslverr_in` in 1: slave error.

## Operation

**FSM states:** IDLE, SETUP, ACCESS, RESP.

- **IDLE**
  - `cmd_ready_out` = 1. This is combinational from state and is the only state with ready high.
  - On accept: capture write, addr and wdata into holding registers. Force `addr[1:0]` = 0 (word aligned). Go to SETUP.
- **SETUP** (exactly 1 cycle)
  - `psel` = 1, `penable` = 0. `pwrite`, `paddr` and `pwdata` driven from the holding registers.
  - Always go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1. All APB outputs remain stable.
  - When `pready` = 1 is sampled:
    - Capture `rdata` = `prdata` for reads, or 0 for writes.
    - Capture `err` = `pslverr`.
    - Go to RESP.
  - With `pready` = 0: remain in ACCESS. Timeout handling is described under Configuration.
- **RESP**
  - `psel` = `penable` = 0; `rsp_valid_out` = 1. `rsp_*` fields stay stable until the handshake.
  - When `rsp_ready_in` = 1: go to IDLE.
- **APB address/data when idle:** `paddr`/`pwdata` hold their last value. Only `psel`/`penable` indicate activity.

**Reset values:** `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err`, `rsp_write` = 0; `paddr` = 0; `pwdata` = 0; `rsp_rdata` = 0; state = IDLE, so `cmd_ready_out` = 1 in the first cycle after reset.

**Boundary conditions**
- **Reset mid-transaction:** the transaction is abandoned. `psel`/`penable` are low in the cycle after reset is sampled. No response is produced.
- **`pslverr` with `pready` low:** ignored. Error is sampled only with `pready`.
- **`rsp_ready_in` held low:** stall indefinitely in RESP. No new command is accepted.
- **`cmd_valid_in` deasserted without acceptance:** no effect.

## Timing

- Accept at edge 0. SETUP during cycle 1. ACCESS during cycle 2.
- Zero wait states: `rsp_valid_out` high in cycle 3.
- Each `pready`-low cycle adds 1 cycle.
- Back-to-back throughput with `rsp_ready_in` held high: one command per 4 cycles.
- All outputs except `cmd_ready_out` are registered.
- The register bank may deassert `pready` for one cycle on a packet-write conflict. This must be absorbed as a normal wait state.

## Configuration

- **`HSSL_APB_TIMEOUT_EN` defined**
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `pready` = 0.
  - When the count reaches `TIMEOUT_CYCLES`:
    - Terminate the transfer: `psel`/`penable` go low.
    - Go to RESP with `rsp_err_out` = 1 and `rsp_rdata_out` = 32'hdead_beef, for both reads and writes.
- **Not defined**
  - No counter logic.
  - ACCESS waits for `pready` indefinitely.

## Structure

- **Package `hssl_apb_pkg`**
  - FSM state enum: IDLE, SETUP, ACCESS, RESP.
  - `HSSL_APB_DEAD_BEEF` = 32'hdead_beef.
  - Register-section constants used by benches and initiators: HREGS = 0, KREGS = 1, MREGS = 2, RREGS = 3, CREGS = 4, AREGS = 5, SREGS = 6.
  - Address field positions: section at bit 6, width 3; register number at bit 2, width 4.
- **Sub-modules:** none. The FSM, holding registers and timeout counter live in one module.

## Test plan

- **Write with zero wait states:** write, addr 40'h104 (CREGS, reg 1), wdata 32'h1234_5678, `pready` tied 1.
  - `psel` high cycles 1–2, `penable` high cycle 2 only, `paddr` = 40'h104.
  - `rsp_valid` in cycle 3 with err = 0, rdata = 0, write = 1.
- **Read with wait states:** read addr 40'h084 (MREGS, reg 1), `pready` low 3 cycles, `prdata` = 32'hcafe_f00d.
  - ACCESS lasts 4 cycles with APB outputs stable.
  - `rsp_rdata` = 32'hcafe_f00d, `rsp_valid` in cycle 6.
- **Slave error and address alignment:** `pslverr` = 1 with `pready` on a read of addr 40'h003.
  - `paddr` = 40'h000 and `rsp_err` = 1.
- **Response backpressure:** `rsp_ready` low 5 cycles, with `cmd_valid` held high and a second command pending.
  - `cmd_ready` stays 0 until the response handshake.
  - The second command's SETUP starts 2 cycles after the handshake.
- **Timeout (`HSSL_APB_TIMEOUT_EN`, TIMEOUT_CYCLES = 4):** `pready` stuck low.
  - Transfer terminates after 4 ACCESS cycles.
  - Response has err = 1, rdata = 32'hdead_beef.
  - Without the macro the block is still in ACCESS after 1000 cycles.
- **Reset mid-transaction:** assert `reset` during ACCESS.
  - Next cycle: `psel` = 0, `rsp_valid` = 0, `cmd_ready` = 1, no response emitted.
